// File: rtl/load_ext_pkg.sv
// load_ext_pkg: load opcode encodings and offset-width helper shared by the load extension unit
package load_ext_pkg;
  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWU = 4'd5,
    OP_LD  = 4'd6,
    OP_LWL = 4'd7,
    OP_LWR = 4'd8
  } load_op_e;
  function automatic int off_w(int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/load_ext_align.sv
// load_ext_align: byte/half/word select and extend, plus LWL/LWR merge when LOAD_EXT_LWLR_EN is defined
module load_ext_align import load_ext_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]               op_i,
  input  logic [off_w(DATA_W)-1:0] off_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [DATA_W-1:0]        rt_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     adel_o
);
  logic [31:0] w;
  logic [15:0] h;
  logic [7:0]  b;
  logic        is_half, is_word, is_ld, mis, lr_op;
  logic [31:0] lr;
  assign w = 32'(data_i >> {off_i, 3'b000});
  assign h = w[15:0];
  assign b = w[7:0];
  assign is_half = op_i == OP_LH || op_i == OP_LHU;
  assign is_word = op_i == OP_LW || (DATA_W == 64 && op_i == OP_LWU);
  assign is_ld   = DATA_W == 64 && op_i == OP_LD;
  assign mis = (is_half && off_i[0]) || (is_word && off_i[1:0] != 2'b00) || (is_ld && off_i != '0);
`ifdef LOAD_EXT_LWLR_EN
  logic [1:0]  lb;
  logic [31:0] mem, rt, lwl, lwr;
  assign lb  = off_i[1:0];
  assign mem = 32'(data_i);
  assign rt  = 32'(rt_i);
  // shift the memory word into place, rt fills whichever bytes the shift vacated
  assign lwl = (mem << {~lb, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {~lb, 3'b000}));
  assign lwr = (mem >> {lb, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {lb, 3'b000}));
  assign lr_op = op_i == OP_LWL || op_i == OP_LWR;
  assign lr = op_i == OP_LWL ? lwl : lwr;
`else
  logic unused_rt;
  assign unused_rt = ^rt_i;
  assign lr_op = 1'b0;
  assign lr = '0;
`endif
  always_comb begin
    adel_o = mis;
    data_o = mis                               ? '0 :
             op_i == OP_LB                     ? DATA_W'($signed(b)) :
             op_i == OP_LBU                    ? DATA_W'(b) :
             op_i == OP_LH                     ? DATA_W'($signed(h)) :
             op_i == OP_LHU                    ? DATA_W'(h) :
             op_i == OP_LW                     ? DATA_W'($signed(w)) :
             DATA_W == 64 && op_i == OP_LWU    ? DATA_W'(w) :
             is_ld                             ? data_i :
             lr_op                             ? DATA_W'($signed(lr)) : '0;
  end
endmodule

// File: rtl/load_ext_unit.sv
// load_ext_unit: load result formatting into a DEPTH-entry output FIFO (LWL/LWR via LOAD_EXT_LWLR_EN)
module load_ext_unit import load_ext_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [off_w(DATA_W)-1:0] in_addr_lo,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W-1:0]        in_rt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_adel
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_W + TAG_W + 1;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] res;
  logic              adel, push, pop;
  load_ext_align #(.DATA_W(DATA_W)) u_align (
    .op_i  (in_op),
    .off_i (in_addr_lo),
    .data_i(in_data),
    .rt_i  (in_rt),
    .data_o(res),
    .adel_o(adel)
  );
  assign out_valid = cnt_q != '0;
  assign pop = out_valid && out_ready;
  assign in_ready = cnt_q != CW'(DEPTH) || pop;
  assign push = in_valid && in_ready;
  always_comb begin
    wr_d  = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d  = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {adel, in_tag, res};
  end
  // storage is not reset, so the head is masked to zero whenever the buffer is empty
  assign {out_adel, out_tag, out_data} = out_valid ? mem_q[rd_q] : '0;
endmodule

// File: doc/load_ext_unit.md
LOAD_EXT_UNIT -- requirements
Module: load_ext_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning load-result width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning output buffer entries; legal values are 2 to 8.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when high together with in_valid.
REQ-008 SHALL have port in_op  input  4  load opcode, encoded per load_ext_pkg.
REQ-009 SHALL have port in_addr_lo  input  $clog2(DATA_W/8)  byte offset of the address.
REQ-010 SHALL have port in_data  input  DATA_W  aligned memory word.
REQ-011 SHALL have port in_rt  input  DATA_W  current destination value, used by LWL/LWR merge.
REQ-012 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-013 SHALL have port out_valid  output  1  buffer head valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the head.
REQ-015 SHALL have ports out_data (DATA_W), out_tag (TAG_W) and out_adel (1), all outputs, giving the head result, its tag and its address-error flag.

Function
REQ-016 SHALL implement the ops LB/LBU/LH/LHU as byte/halfword selects by offset, sign- or zero-extended to DATA_W.
REQ-017 SHALL implement LW as a sign-extended word; on DATA_W=64 it SHALL also implement LWU (zero-extended word) and LD (full doubleword).
REQ-018 SHALL, on DATA_W=32, treat LWU and LD as undefined ops.
REQ-019 SHALL set out_adel=1 and data=0 when an op is misaligned: halfword with offset bit0 set; word with offset[1:0]≠0; LD with offset≠0.
REQ-020 SHALL produce data=0 and adel=0 for an undefined op.
REQ-021 SHALL push the result into a DEPTH-entry FIFO on an accepted request (in_valid && in_ready).
REQ-022 SHALL pop the head on out_valid && out_ready.
REQ-023 SHALL give a minimum latency of 1 cycle: a request accepted in cycle N makes out_valid=1 in cycle N+1.
REQ-024 SHALL drive in_ready = (count<DEPTH) || (out_valid && out_ready), so push and pop in the same cycle are allowed when full.
REQ-025 SHALL leave count unchanged on a simultaneous push and pop; on empty with no push, out_valid SHALL stay 0.
REQ-026 SHALL wrap the read and write pointers from DEPTH-1 to 0, and count SHALL never exceed DEPTH.
REQ-027 SHALL hold out_data, out_tag and out_adel stable while out_valid && !out_ready.

Reset
REQ-028 SHALL, when reset_n=0 at a clk edge, set count, both pointers and out_valid to 0, and out_data, out_tag and out_adel to 0.
REQ-029 SHALL hold in_ready=1 from the first cycle after reset.
REQ-030 SHALL discard buffered entries on reset mid-operation, with no pop reported.

Configuration
REQ-031 SHALL, with macro LOAD_EXT_LWLR_EN defined, support LWL/LWR on the low 32 bits (offset b = in_addr_lo[1:0], little-endian).
REQ-032 SHALL, for LWL, return mem bytes 0..b placed in the top b+1 bytes, with rt supplying the remaining low bytes.
REQ-033 SHALL, for LWR, return mem bytes b..3 placed in the low 4-b bytes, with rt supplying the remaining high bytes.
REQ-034 SHALL never raise adel for LWL/LWR, and SHALL sign-extend bit 31 when DATA_W=64.
REQ-035 SHALL, without LOAD_EXT_LWLR_EN, treat LWL/LWR as undefined ops, and in_rt SHALL be unused.

Structure
REQ-036 SHALL take the op encodings (LB, LBU, LH, LHU, LW, LWU, LD, LWL, LWR) and the offset-width function from package load_ext_pkg.
REQ-037 SHALL place the combinational select/extend/merge logic in sub-module load_ext_align; the FIFO and handshake SHALL reside in load_ext_unit.

Verification
REQ-038 SHALL cover: LB with in_data=32'h8070_FF12, offset 1 -> 32'hFFFF_FFFF after 1 cycle; LBU at offset 3 -> 32'h0000_0080.
REQ-039 SHALL cover: LH with offset 1 -> out_adel=1 and out_data=0; LHU with offset 2 on 32'h8070_0000 -> 32'h0000_8070.
REQ-040 SHALL cover: hold out_ready=0 with DEPTH=2 and send 3 requests -> in_ready=0 after 2; then with out_ready=1 and in_valid=1, a push and pop occur in the same cycle and count stays at 2.
REQ-041 SHALL cover, with LOAD_EXT_LWLR_EN: LWL offset 1 on mem 32'hAABBCCDD, rt 32'h11223344 -> 32'hCCDD3344; LWR offset 1 -> 32'h11AABBCC.
REQ-042 SHALL cover, with DATA_W=64: LW offset 4 on 64'h8000_0001_0000_0000 -> 64'hFFFF_FFFF_8000_0001; LD offset 4 -> out_adel=1.
REQ-043 SHALL cover: fill 2 entries, assert reset_n=0 for 1 cycle -> out_valid=0 and in_ready=1 next cycle.
